// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Shares the single register-file write port between the in-order
//             pipeline writeback (port A) and the long-latency return path
//             (port B). Port B results are buffered in a small FIFO. A
//             per-register pending bitmap lets decode stall on hazards
//             against buffered results. The regfile write goes through one
//             output register stage.
//  Ports    : clk, rst (async, active-high)
//             a_valid_i/a_ready_o/a_rd_i/a_data_i  pipeline writeback
//             b_valid_i/b_ready_o/b_rd_i/b_data_i  long-latency results
//             rf_we_o/rf_waddr_o/rf_wdata_o        registered regfile write
//             pend_o                               registers with queued B writes
//  Config   : RF_WB_RR_EN defined   -> round-robin A/B arbitration
//             RF_WB_RR_EN undefined -> fixed A priority
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [4:0]      a_rd_i,
    input  logic [XLEN-1:0] a_data_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [4:0]      b_rd_i,
    input  logic [XLEN-1:0] b_data_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic [31:0]     pend_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Port-B FIFO storage and bookkeeping
    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Output stage
    logic            rf_we_q,    rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            out_b_q,    out_b_d;   // output stage holds a B write

    logic full, empty, push, grant_a, grant_b;
    logic [PW-1:0] pend_idx;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = b_valid_i && !full;

`ifdef RF_WB_RR_EN
    // Token set means B wins the next contended cycle.
    logic tok_b_q;
`endif

    // Grant selection depends only on state and a_valid_i, so b_valid_i
    // never reaches a_ready_o combinationally.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (full) begin
            grant_b = 1'b1;
        end
`ifdef RF_WB_RR_EN
        else if (a_valid_i && !empty) begin
            grant_b = tok_b_q;
            grant_a = !tok_b_q;
        end
`endif
        else if (a_valid_i) begin
            grant_a = 1'b1;
        end else if (!empty) begin
            grant_b = 1'b1;
        end
    end

    assign a_ready_o = !a_valid_i || grant_a;
    assign b_ready_o = !full;

    // Output-stage next state; rd=0 is consumed but never written.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        out_b_d    = 1'b0;
        if (grant_a) begin
            rf_we_d    = (a_rd_i != 5'd0);
            rf_waddr_d = a_rd_i;
            rf_wdata_d = a_data_i;
        end else if (grant_b) begin
            rf_we_d    = (fifo_rd_q[rptr_q] != 5'd0);
            rf_waddr_d = fifo_rd_q[rptr_q];
            rf_wdata_d = fifo_data_q[rptr_q];
            out_b_d    = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, grant_b})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            out_b_q    <= 1'b0;
        end else begin
            if (push)    wptr_q <= wptr_q + PW'(1);
            if (grant_b) rptr_q <= rptr_q + PW'(1);
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            out_b_q    <= out_b_d;
        end
    end

`ifdef RF_WB_RR_EN
    // Token only moves on a contended grant and then points at the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_b_q <= 1'b0;
        end else if (a_valid_i && !empty) begin
            tok_b_q <= grant_a;
        end
    end
`endif

    // Payload storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= b_rd_i;
            fifo_data_q[wptr_q] <= b_data_i;
        end
    end

    // Pending bitmap: live FIFO entries plus a B write in the output stage.
    always_comb begin
        pend_o   = 32'd0;
        pend_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pend_idx = rptr_q + PW'(k);
            if ((CW'(k) < cnt_q) && (fifo_rd_q[pend_idx] != 5'd0)) begin
                pend_o[fifo_rd_q[pend_idx]] = 1'b1;
            end
        end
        if (out_b_q && rf_we_q) begin
            pend_o[rf_waddr_q] = 1'b1;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Self-checking bench for rf_wb_arbiter: a directed vector table,
//             hand-written reset and contention sequences, and randomized
//             traffic compared against a queue-based reference model.
//  Config   : honours RF_WB_RR_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [4:0]      a_rd, b_rd, rf_waddr;
    logic [XLEN-1:0] a_data, b_data, rf_wdata;
    logic            rf_we;
    logic [31:0]     pend;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid_i  (a_valid),
        .a_ready_o  (a_ready),
        .a_rd_i     (a_rd),
        .a_data_i   (a_data),
        .b_valid_i  (b_valid),
        .b_ready_o  (b_ready),
        .b_rd_i     (b_rd),
        .b_data_i   (b_data),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata),
        .pend_o     (pend)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we, m_outb, m_turn_b;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_clear();
        mq.delete();
        m_we = 1'b0; m_outb = 1'b0; m_turn_b = 1'b0;
        m_addr = 5'd0; m_data = 32'd0;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
    endtask

    // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step_model(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                              output logic a_acc, output logic b_acc);
        logic        full, ga, gb;
        logic [31:0] ep;
        ent_t        e;
        drive(av, ard, ad, bv, brd, bd);
        @(negedge clk);
        full = (mq.size() == DEPTH);
        ga = 1'b0; gb = 1'b0;
        if (full) gb = 1'b1;
`ifdef RF_WB_RR_EN
        else if (av && mq.size() > 0) begin
            if (m_turn_b) gb = 1'b1; else ga = 1'b1;
        end
`endif
        else if (av) ga = 1'b1;
        else if (mq.size() > 0) gb = 1'b1;
        ep = 32'd0;
        foreach (mq[i]) if (mq[i].rd != 0) ep = ep | (32'd1 << mq[i].rd);
        if (m_outb && m_we) ep = ep | (32'd1 << m_addr);
        chk("a_ready", {31'd0, a_ready}, {31'd0, (!av || ga)});
        chk("b_ready", {31'd0, b_ready}, {31'd0, !full});
        chk("pend", pend, ep);
        chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        if (m_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
            chk("rf_wdata", rf_wdata, m_data);
        end
        a_acc = av && ga;
        b_acc = bv && !full;
        @(posedge clk);
`ifdef RF_WB_RR_EN
        if (av && mq.size() > 0) m_turn_b = ga;
`endif
        if (ga) begin
            m_we = (ard != 0); m_addr = ard; m_data = ad; m_outb = 1'b0;
        end else if (gb) begin
            e = mq.pop_front();
            m_we = (e.rd != 0); m_addr = e.rd; m_data = e.data; m_outb = 1'b1;
        end else begin
            m_we = 1'b0; m_outb = 1'b0;
        end
        if (b_acc) begin
            e.rd = brd; e.data = bd;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        chk("rst_pend", pend, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        ea_rdy;
        logic        eb_rdy;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic [31:0] epend;
    } vec_t;

    vec_t tbl[16];

    logic        acc_a, acc_b, rav, rbv;
    logic [4:0]  rard, rbrd;
    logic [31:0] rad, rbd;

    initial begin
        // A writeback, B buffering under A streaming, then x0 suppression.
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 5'd1, 32'h101,      1'b1, 5'd7, 32'h11, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 5'd2, 32'h102,      1'b1, 5'd8, 32'h22, 1'b1, 1'b1, 1'b1, 5'd1, 32'h101,      32'h80};
        tbl[5]  = '{1'b1, 5'd3, 32'h103,      1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd2, 32'h102,      32'h180};
        tbl[6]  = '{1'b1, 5'd3, 32'h103,      1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'h11,       32'h180};
        tbl[7]  = '{1'b1, 5'd4, 32'h104,      1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'h103,      32'h100};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd4, 32'h104,      32'h100};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd8, 32'h22,       32'h100};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h33, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0};

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        do_reset();

`ifndef RF_WB_RR_EN
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].bv, tbl[i].brd, tbl[i].bd);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ea_rdy});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].eb_rdy});
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, tbl[i].ewe});
            chk($sformatf("v%0d_pend", i), pend, tbl[i].epend);
            if (tbl[i].ewe) begin
                chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].eaddr});
                chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].edata);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
`endif

        // A valid every cycle while two B results queue up, then drain.
        step_model(1'b1, 5'd1, 32'hA1, 1'b1, 5'd13, 32'hB1, acc_a, acc_b);
        step_model(1'b1, 5'd2, 32'hA2, 1'b1, 5'd14, 32'hB2, acc_a, acc_b);
        for (int i = 0; i < 6; i++) begin
            step_model(1'b1, 5'(3 + i), 32'hA3 + i, 1'b0, 5'd0, 32'd0, acc_a, acc_b);
            if (!acc_a) i--;
        end
        for (int i = 0; i < 3; i++) step_model(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc_a, acc_b);

        // Reset while the FIFO holds x9 and x10.
        step_model(1'b1, 5'd11, 32'hC1, 1'b1, 5'd9,  32'h99, acc_a, acc_b);
        step_model(1'b1, 5'd12, 32'hC2, 1'b1, 5'd10, 32'h1010, acc_a, acc_b);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("drain_pend_before_rst", pend, 32'h600);
        do_reset();
        for (int i = 0; i < 4; i++) step_model(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc_a, acc_b);

        // Randomized traffic; requesters hold their request until accepted.
        acc_a = 1'b1; acc_b = 1'b1; rav = 1'b0; rbv = 1'b0;
        rard = 5'd0; rbrd = 5'd0; rad = 32'd0; rbd = 32'd0;
        for (int i = 0; i < 600; i++) begin
            if (!rav || acc_a) begin
                rav  = ($urandom_range(0, 99) < 65);
                rard = 5'($urandom_range(0, 31));
                rad  = $urandom;
            end
            if (!rbv || acc_b) begin
                rbv  = ($urandom_range(0, 99) < 40);
                rbrd = 5'($urandom_range(0, 31));
                rbd  = $urandom;
            end
            step_model(rav, rard, rad, rbv, rbrd, rbd, acc_a, acc_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
